imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
//  Boot loader upstream of the instruction memory: receives a byte stream (valid/ready), assembles
//  big-endian 32-bit words and writes them into a writable instruction RAM via a write port.
//  Verifies a trailing 32-bit additive checksum and holds the MIPS core in reset until a load
//  passes. Replaces $readmemh initialisation for on-board program loading.
// PARAMETERS
//  DEPTH  64  instruction RAM depth in words (power of 2)
//  AW     6   word-address width, log2(DEPTH)
// PORTS
//  clk         in   1     system clock, all state on posedge
//  reset       in   1     synchronous, active-high
//  start       in   1     1-cycle pulse: begin a load (ignored while busy)
//  len         in   AW+1  words to load, sampled on accepted start; 0 or >DEPTH => DEPTH
//  byte_valid  in   1     byte_data valid
//  byte_data   in   8     stream byte
//  byte_ready  out  1     loader accepts byte this cycle (transfer = valid & ready)
//  imem_we     out  1     instruction RAM write strobe
//  imem_a      out  AW    instruction RAM word address
//  imem_wd     out  32    instruction RAM write data
//  cpu_reset   out  1     reset to MIPS core; high until a load passes checksum
//  busy        out  1     load in progress (LOAD or CHECK)
//  done        out  1     1-cycle pulse: load passed checksum
//  err         out  1     sticky: checksum mismatch; cleared by next accepted start or reset
//  word_count  out  AW+1  words written in current/last load
// BEHAVIOUR
//  Reset: state IDLE; cpu_reset=1; byte_ready, imem_we, busy, done, err=0; imem_a, imem_wd,
//   word_count, byte index, running sum=0. RAM contents untouched.
//  States: IDLE, LOAD, CHECK, RUN, ERROR. All outputs registered.
//  IDLE/RUN/ERROR + start: next cycle LOAD; latch len (clamped); clear sum, word_count, byte idx,
//   err; cpu_reset=1 (reasserted from RUN on the cycle after start). byte_ready=0 outside LOAD/CHECK.
//  LOAD: byte_ready=1. Each transfer shifts byte in; first byte -> bits[31:24], fourth -> [7:0].
//   Cycle after 4th byte transfer: imem_we=1 for exactly 1 cycle, imem_a=word_count[AW-1:0],
//   imem_wd=word; sum+=word (mod 2^32); word_count++. Bytes may keep transferring during that
//   write cycle (no bubble required). When word_count reaches latched len -> CHECK.
//  CHECK: byte_ready=1; assemble 4 checksum bytes same order. Cycle after 4th byte: compare to sum.
//   Match -> RUN: done=1 one cycle, cpu_reset=0, busy=0. Mismatch -> ERROR: err=1, cpu_reset=1.
//   No imem_we in CHECK.
//  start while busy: ignored. byte_valid while byte_ready=0: ignored, no state change.
//  Reset mid-load: immediate return to reset values; partially written words remain in RAM.
//  Address wraps never occur: word_count bounded by clamped len <= DEPTH.
// TESTING
//  len=2, bytes 20 08 00 05 20 09 00 0C + 40 11 00 11 -> writes (0,0x20080005),(1,0x2009000C),
//   done pulse, cpu_reset 1->0, err=0, word_count=2.
//  Same words, checksum 40 11 00 12 -> no done, err=1, cpu_reset stays 1, state ERROR;
//   new start clears err.
//  len=0 -> exactly 64 writes, addrs 0..63, then CHECK; len=100 behaves identically.
//  Random byte_valid gaps and back-to-back bytes -> identical writes/latency (imem_we 1 cycle
//   after 4th byte transfer).
//  start pulses during LOAD -> ignored, len unchanged; start in RUN -> cpu_reset high next cycle.
//  reset asserted after 5 bytes -> all outputs at reset values next cycle; word 0 stays in RAM.

Source files
------------

// File: rtl/imem_loader.sv
// Boot loader for the instruction RAM. It assembles big-endian words from a byte stream,
// writes them to the RAM, checks a trailing additive checksum and releases the core on a pass.
module imem_loader #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW:0]   len,
  input  logic          byte_valid,
  input  logic [7:0]    byte_data,
  output logic          byte_ready,
  output logic          imem_we,
  output logic [AW-1:0] imem_a,
  output logic [31:0]   imem_wd,
  output logic          cpu_reset,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [AW:0]   word_count
);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CHECK, S_RUN, S_ERROR} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] len_q, len_d;
  logic [31:0]   sum_q, sum_d;
  logic [1:0]    idx_q, idx_d;
  logic [23:0]   shift_q, shift_d;

  logic          byte_ready_d, imem_we_d, cpu_reset_d, busy_d, done_d, err_d;
  logic [AW-1:0] imem_a_d;
  logic [31:0]   imem_wd_d;
  logic [CW-1:0] word_count_d;

  logic          xfer;
  logic [31:0]   word_c;
  logic [CW-1:0] len_clamped;
  logic [CW-1:0] wc_inc;

  assign xfer        = byte_valid && byte_ready;
  assign word_c      = {shift_q, byte_data};
  assign wc_inc      = word_count + CW'(1);
  // A zero or oversized length means "fill the whole RAM".
  assign len_clamped = ((len == '0) || (len > CW'(DEPTH))) ? CW'(DEPTH) : len;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      sum_q      <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      byte_ready <= 1'b0;
      imem_we    <= 1'b0;
      imem_a     <= '0;
      imem_wd    <= '0;
      cpu_reset  <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      word_count <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      sum_q      <= sum_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      byte_ready <= byte_ready_d;
      imem_we    <= imem_we_d;
      imem_a     <= imem_a_d;
      imem_wd    <= imem_wd_d;
      cpu_reset  <= cpu_reset_d;
      busy       <= busy_d;
      done       <= done_d;
      err        <= err_d;
      word_count <= word_count_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    sum_d        = sum_q;
    idx_d        = idx_q;
    shift_d      = shift_q;
    imem_we_d    = 1'b0;
    imem_a_d     = imem_a;
    imem_wd_d    = imem_wd;
    cpu_reset_d  = cpu_reset;
    done_d       = 1'b0;
    err_d        = err;
    word_count_d = word_count;

    case (state_q)
      S_IDLE, S_RUN, S_ERROR: begin
        if (start) begin
          state_d      = S_LOAD;
          len_d        = len_clamped;
          sum_d        = '0;
          idx_d        = '0;
          word_count_d = '0;
          err_d        = 1'b0;
          cpu_reset_d  = 1'b1;
        end
      end
      S_LOAD: begin
        if (xfer) begin
          shift_d = {shift_q[15:0], byte_data};
          idx_d   = 2'(idx_q + 2'd1);
          if (idx_q == 2'd3) begin
            imem_we_d    = 1'b1;
            imem_a_d     = word_count[AW-1:0];
            imem_wd_d    = word_c;
            sum_d        = sum_q + word_c;
            word_count_d = wc_inc;
            if (wc_inc == len_q) state_d = S_CHECK;
          end
        end
      end
      S_CHECK: begin
        if (xfer) begin
          shift_d = {shift_q[15:0], byte_data};
          idx_d   = 2'(idx_q + 2'd1);
          if (idx_q == 2'd3) begin
            if (word_c == sum_q) begin
              state_d     = S_RUN;
              done_d      = 1'b1;
              cpu_reset_d = 1'b0;
            end else begin
              state_d     = S_ERROR;
              err_d       = 1'b1;
              cpu_reset_d = 1'b1;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Handshake and busy track the state being entered so they are valid on arrival.
    byte_ready_d = (state_d == S_LOAD) || (state_d == S_CHECK);
    busy_d       = byte_ready_d;
  end
endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected RAM writes are queued as bytes are accepted
// and popped when the loader strobes imem_we.
module tb_imem_loader;
  localparam int unsigned AW = 6;
  localparam int unsigned CW = AW + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [CW-1:0] len_in = '0;
  logic          byte_valid = 1'b0;
  logic [7:0]    byte_data = '0;
  logic          byte_ready, imem_we, cpu_reset, busy, done, err;
  logic [AW-1:0] imem_a;
  logic [31:0]   imem_wd;
  logic [CW-1:0] word_count;

  imem_loader #(.DEPTH(64), .AW(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .len(len_in),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .imem_we(imem_we), .imem_a(imem_a), .imem_wd(imem_wd),
    .cpu_reset(cpu_reset), .busy(busy), .done(done), .err(err),
    .word_count(word_count)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [AW-1:0] a;
    logic [31:0]   d;
    int unsigned   c;
  } wr_t;

  wr_t        exp_q[$];
  wr_t        mon_e;
  logic [7:0] bq[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Every write strobe must match the oldest outstanding expected write, including its cycle.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", 64'(imem_a), 64'hFFFF);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", 64'(imem_a), 64'(mon_e.a));
        check("wr_data", 64'(imem_wd), 64'(mon_e.d));
        check("wr_cycle", 64'(cyc), 64'(mon_e.c));
      end
    end
  end

  task automatic push_word(input logic [31:0] w);
    bq.push_back(w[31:24]);
    bq.push_back(w[23:16]);
    bq.push_back(w[15:8]);
    bq.push_back(w[7:0]);
  endtask

  task automatic do_start(input logic [CW-1:0] l);
    start  = 1'b1;
    len_in = l;
    @(negedge clk);
    start  = 1'b0;
  endtask

  // Streams bq from a negedge; returns at the negedge after the last accepted byte.
  task automatic send(input int nw, input int gap_pct, input bit mid_start);
    int  i = 0;
    int  idle = 0;
    bit  pulsed = 1'b0;
    while (i < bq.size()) begin
      start = 1'b0;
      if (mid_start && !pulsed && i == 5) begin
        start  = 1'b1;
        len_in = 7'd5;
        pulsed = 1'b1;
      end
      byte_valid = ($urandom_range(99) >= 32'(gap_pct));
      byte_data  = bq[i];
      if (byte_valid && byte_ready) begin
        if ((i % 4) == 3 && (i / 4) < nw)
          exp_q.push_back('{AW'(i / 4), {bq[i-3], bq[i-2], bq[i-1], bq[i]}, cyc + 1});
        i++;
        idle = 0;
      end else begin
        idle++;
        if (idle > 200) begin
          check("stream_stall", 64'(i), 64'(bq.size()));
          break;
        end
      end
      @(negedge clk);
    end
    byte_valid = 1'b0;
    start      = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_cpu_reset"}, 64'(cpu_reset), 64'd1);
    check({tag, "_ready"}, 64'(byte_ready), 64'd0);
    check({tag, "_we"}, 64'(imem_we), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_err"}, 64'(err), 64'd0);
    check({tag, "_wc"}, 64'(word_count), 64'd0);
    check({tag, "_addr"}, 64'(imem_a), 64'd0);
    check({tag, "_wd"}, 64'(imem_wd), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got=%0d exp=finish", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] words[64];
    logic [31:0] sum;

    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_reset_vals("rst");
    reset = 1'b0;
    @(negedge clk);

    // Two-word load with a good checksum and an ignored start mid-load.
    bq.delete();
    push_word(32'h2008_0005);
    push_word(32'h2009_000C);
    push_word(32'h4011_0011);
    do_start(7'd2);
    check("load_busy", 64'(busy), 64'd1);
    check("load_ready", 64'(byte_ready), 64'd1);
    send(2, 0, 1'b1);
    check("pass_done", 64'(done), 64'd1);
    check("pass_cpu_reset", 64'(cpu_reset), 64'd0);
    check("pass_err", 64'(err), 64'd0);
    check("pass_busy", 64'(busy), 64'd0);
    check("pass_wc", 64'(word_count), 64'd2);
    @(negedge clk);
    check("pass_done_pulse", 64'(done), 64'd0);
    check("run_cpu_reset", 64'(cpu_reset), 64'd0);

    // Bad checksum: start from RUN reasserts cpu_reset, then ERROR.
    bq[11] = 8'h12;
    do_start(7'd2);
    check("restart_cpu_reset", 64'(cpu_reset), 64'd1);
    send(2, 30, 1'b0);
    check("bad_done", 64'(done), 64'd0);
    check("bad_err", 64'(err), 64'd1);
    check("bad_cpu_reset", 64'(cpu_reset), 64'd1);
    check("bad_busy", 64'(busy), 64'd0);
    byte_valid = 1'b1;
    repeat (3) @(negedge clk);
    byte_valid = 1'b0;
    check("err_sticky", 64'(err), 64'd1);
    check("err_ready", 64'(byte_ready), 64'd0);
    bq[11] = 8'h11;
    do_start(7'd2);
    check("restart_err_clr", 64'(err), 64'd0);
    send(2, 40, 1'b0);
    check("retry_done", 64'(done), 64'd1);

    // Full-depth loads: len=0 back-to-back, then len=100 with gaps.
    bq.delete();
    sum = '0;
    for (int k = 0; k < 64; k++) begin
      words[k] = $urandom();
      sum += words[k];
      push_word(words[k]);
    end
    push_word(sum);
    do_start(7'd0);
    send(64, 0, 1'b0);
    check("len0_done", 64'(done), 64'd1);
    check("len0_wc", 64'(word_count), 64'd64);
    @(negedge clk);
    do_start(7'd100);
    send(64, 25, 1'b0);
    check("len100_done", 64'(done), 64'd1);
    check("len100_wc", 64'(word_count), 64'd64);
    check("len100_cpu_reset", 64'(cpu_reset), 64'd0);

    // Reset after five bytes: word 0 written, then everything back to reset values.
    bq.delete();
    push_word(32'hDEAD_BEEF);
    bq.push_back(8'h55);
    do_start(7'd2);
    send(1, 0, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    check_reset_vals("midrst");
    reset = 1'b0;
    @(negedge clk);

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
